// File: rtl/mean_decimator.sv
// mean_decimator
//   Back end of the per-channel filter chain. Drops the filter's fill-up
//   transient (WARMUP enabled samples) and then averages blocks of
//   2**DECIM_LOG2 signed samples. The average is floored toward -inf.
//   Each block result goes into a first-word-fall-through FIFO, which is
//   read out over a valid/ready handshake.
//
//   Optional feature macro: PEAK_HOLD_EN
//     Adds DOUT_PEAK, the saturated largest |sample| of each block. The
//     peak is stored next to the average in the same FIFO word.
//
// Ports
//   CLK         in   system clock, rising edge
//   RESET_n     in   synchronous reset, active low
//   DATA_IN     in   signed filtered sample
//   DATA_IN_EN  in   sample strobe
//   DOUT        out  signed block average (FIFO head)
//   DOUT_VALID  out  FIFO not empty
//   DOUT_READY  in   consumer accepts DOUT this cycle
//   FIFO_LEVEL  out  words stored, 0..2**FIFO_DEPTH_LOG2
//   OVERFLOW    out  sticky flag, a block result was dropped
//   OVF_CLR     in   clears OVERFLOW (a drop on the same edge wins)
//   DOUT_PEAK   out  block peak magnitude (PEAK_HOLD_EN builds only)
module mean_decimator #(
    parameter int DECIM_LOG2      = 3,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int WARMUP          = 48
) (
    input  logic                       CLK,
    input  logic                       RESET_n,
    input  logic [15:0]                DATA_IN,
    input  logic                       DATA_IN_EN,
    output logic [15:0]                DOUT,
    output logic                       DOUT_VALID,
    input  logic                       DOUT_READY,
    output logic [FIFO_DEPTH_LOG2:0]   FIFO_LEVEL,
    output logic                       OVERFLOW,
    input  logic                       OVF_CLR
`ifdef PEAK_HOLD_EN
    ,
    output logic [15:0]                DOUT_PEAK
`endif
);

    localparam int ACC_W = 16 + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
    localparam int PTR_W = FIFO_DEPTH_LOG2;
    localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [7:0]       WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
`ifdef PEAK_HOLD_EN
    localparam int WORD_W = 32;
`else
    localparam int WORD_W = 16;
`endif

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_ACCUM  = 1'b1
    } state_t;

    state_t                     state_r, state_next_s;
    logic [7:0]                 warm_cnt_r, warm_cnt_next_s;
    logic [CNT_W-1:0]           blk_cnt_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [ACC_W-1:0]    sum_s;
    logic [15:0]                avg_s;
    logic                       accept_s;
    logic                       last_s;
    logic                       push_s;
    logic [WORD_W-1:0]          push_word_s;

    logic [WORD_W-1:0]          mem_r [DEPTH];
    logic [PTR_W-1:0]           rd_ptr_r, wr_ptr_r, rd_ptr_inc_s;
    logic [LVL_W-1:0]           level_r, level_next_s;
    logic [WORD_W-1:0]          dout_r, head_next_s;
    logic                       valid_r;
    logic                       ovf_r, ovf_next_s;
    logic                       pop_s, full_s, wr_en_s, drop_s;

`ifdef PEAK_HOLD_EN
    logic [15:0]                peak_r, abs_s, peak_now_s;

    // Magnitude of a 16-bit two's complement value; -32768 saturates.
    function automatic logic [15:0] abs_sat(input logic [15:0] x);
        if (x == 16'h8000) begin
            return 16'h7FFF;
        end else if (x[15]) begin
            return 16'(~x + 16'd1);
        end else begin
            return x;
        end
    endfunction

    // Running block peak including the current sample.
    always_comb begin
        abs_s      = abs_sat(DATA_IN);
        peak_now_s = (abs_s > peak_r) ? abs_s : peak_r;
    end
`endif

    // FSM next state: count off warm-up samples, then stay in ACCUM.
    always_comb begin
        state_next_s    = state_r;
        warm_cnt_next_s = warm_cnt_r;
        accept_s        = 1'b0;
        case (state_r)
            ST_WARMUP: begin
                if (WARMUP == 0) begin
                    state_next_s = ST_ACCUM;
                end else if (DATA_IN_EN) begin
                    if (warm_cnt_r == WARM_LAST) begin
                        state_next_s = ST_ACCUM;
                    end else begin
                        warm_cnt_next_s = warm_cnt_r + 8'd1;
                    end
                end else begin
                    state_next_s = ST_WARMUP;
                end
            end
            ST_ACCUM: begin
                if (DATA_IN_EN) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            default: begin
                state_next_s = ST_WARMUP;
            end
        endcase
    end

    // Block arithmetic. The accumulator holds at most D-1 samples, so the
    // sum of D samples always fits in ACC_W bits.
    always_comb begin
        sum_s  = acc_r + ACC_W'($signed(DATA_IN));
        avg_s  = 16'(sum_s >>> DECIM_LOG2);
        last_s = (blk_cnt_r == BLK_LAST);
        push_s = accept_s && last_s;
`ifdef PEAK_HOLD_EN
        push_word_s = {peak_now_s, avg_s};
`else
        push_word_s = avg_s;
`endif
    end

    // FIFO control. Full and empty are taken from the level counter.
    // A push into a full FIFO is accepted only when a pop happens on the
    // same edge.
    always_comb begin
        pop_s        = valid_r && DOUT_READY;
        full_s       = (level_r == LVL_FULL);
        wr_en_s      = push_s && (!full_s || pop_s);
        drop_s       = push_s && full_s && !pop_s;
        rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);
        case ({wr_en_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase
        // Registered head word: the next entry after a pop, the incoming
        // word when the FIFO drains to it, or the last value when empty.
        if (pop_s) begin
            if (level_r >= LVL_W'(2)) begin
                head_next_s = mem_r[rd_ptr_inc_s];
            end else if (wr_en_s) begin
                head_next_s = push_word_s;
            end else begin
                head_next_s = dout_r;
            end
        end else if ((level_r == LVL_W'(0)) && wr_en_s) begin
            head_next_s = push_word_s;
        end else begin
            head_next_s = dout_r;
        end
        if (drop_s) begin
            ovf_next_s = 1'b1;
        end else if (OVF_CLR) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // State register, warm-up counter and block accumulator.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_r    <= ST_WARMUP;
            warm_cnt_r <= 8'd0;
            blk_cnt_r  <= {CNT_W{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
`ifdef PEAK_HOLD_EN
            peak_r     <= 16'd0;
`endif
        end else begin
            state_r    <= state_next_s;
            warm_cnt_r <= warm_cnt_next_s;
            if (accept_s) begin
                if (last_s) begin
                    blk_cnt_r <= {CNT_W{1'b0}};
                    acc_r     <= {ACC_W{1'b0}};
`ifdef PEAK_HOLD_EN
                    peak_r    <= 16'd0;
`endif
                end else begin
                    blk_cnt_r <= blk_cnt_r + CNT_W'(1);
                    acc_r     <= sum_s;
`ifdef PEAK_HOLD_EN
                    peak_r    <= peak_now_s;
`endif
                end
            end
        end
    end

    // FIFO storage; contents need no reset because the level gates reads.
    always_ff @(posedge CLK) begin
        if (RESET_n && wr_en_s) begin
            mem_r[wr_ptr_r] <= push_word_s;
        end
    end

    // FIFO pointers, level, registered head and flags.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            dout_r   <= {WORD_W{1'b0}};
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            level_r <= level_next_s;
            dout_r  <= head_next_s;
            valid_r <= (level_next_s != LVL_W'(0));
            ovf_r   <= ovf_next_s;
        end
    end

    assign DOUT       = dout_r[15:0];
    assign DOUT_VALID = valid_r;
    assign FIFO_LEVEL = level_r;
    assign OVERFLOW   = ovf_r;
`ifdef PEAK_HOLD_EN
    assign DOUT_PEAK  = dout_r[31:16];
`endif

endmodule
